// File: rtl/axo_fetch_queue_pkg.sv
// Shared types and field layout for the Axolotl fetch queue.
// An entry is packed as {fault, pc, inst}, with inst in the low bits.
package axo_fetch_queue_pkg;

  typedef enum logic {
    XQ_FETCH = 1'b0,
    XQ_HALT  = 1'b1
  } xq_state_e;

  localparam logic [1:0] AXO_INST_ALIGN_MASK = 2'b11;
  localparam int         AXO_INST_W          = 32;
  localparam int         AXO_INST_LSB        = 0;
  localparam int         AXO_PC_LSB          = AXO_INST_W;

  function automatic int axo_fault_bit(input int xlen);
    return AXO_INST_W + xlen;
  endfunction

  function automatic int axo_entry_w(input int xlen);
    return AXO_INST_W + xlen + 1;
  endfunction

endpackage

// File: rtl/axo_fetch_queue_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count.
// The head word is read combinationally from storage; flush wins over push and pop.
module axo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/axo_fetch_queue.sv
// Instruction prefetch queue: fetches ahead on the program bus, tags entries with
// PC and a misalignment fault marker, and flushes on redirect.
module axo_fetch_queue
  import axo_fetch_queue_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       prog_re,
  input  logic                       prog_ready,
  output logic [XLEN-1:0]            prog_addr,
  input  logic [31:0]                prog_data,
  input  logic                       redir,
  input  logic [XLEN-1:0]            redir_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_inst,
  output logic [XLEN-1:0]            deq_pc,
  output logic                       deq_fault,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int ENTRY_W   = axo_entry_w(XLEN);
  localparam int FAULT_BIT = axo_fault_bit(XLEN);

  xq_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             fetch_re;
  logic             push;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic             fifo_full, fifo_empty;
  logic             pc_aligned;

  assign pc_aligned = ((pc_q[1:0] & AXO_INST_ALIGN_MASK) == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_re   = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    if (redir) begin
      pc_d    = redir_pc;
      state_d = XQ_FETCH;
    end else begin
      case (state_q)
        XQ_FETCH: begin
          if (pc_aligned) begin
            fetch_re = !fifo_full;
            if (fetch_re && prog_ready) begin
              push       = 1'b1;
              push_entry = {1'b0, pc_q, prog_data};
              pc_d       = pc_q + XLEN'(4);
            end
          end else if (!fifo_full) begin
            // Misaligned PC: emit one fault marker instead of a bus access, then stall.
            push       = 1'b1;
            push_entry = {1'b1, pc_q, 32'h0};
            state_d    = XQ_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= XQ_FETCH;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  axo_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .flush_i     (redir),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (deq_ready),
    .pop_data_o  (head_entry),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Head fields read as zero when empty so reset and idle show a clean bus.
  assign prog_re   = rst && fetch_re;
  assign prog_addr = pc_q;
  assign deq_valid = !fifo_empty;
  assign deq_inst  = deq_valid ? head_entry[AXO_INST_LSB +: AXO_INST_W] : 32'h0;
  assign deq_pc    = deq_valid ? head_entry[AXO_PC_LSB +: XLEN] : '0;
  assign deq_fault = deq_valid && head_entry[FAULT_BIT];

endmodule

// File: tb/tb_axo_fetch_queue.sv
// Bench for axo_fetch_queue: directed table, hand-written corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_axo_fetch_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            prog_re;
  logic            prog_ready;
  logic [XLEN-1:0] prog_addr;
  logic [31:0]     prog_data;
  logic            redir;
  logic [XLEN-1:0] redir_pc;
  logic            deq_valid;
  logic            deq_ready;
  logic [31:0]     deq_inst;
  logic [XLEN-1:0] deq_pc;
  logic            deq_fault;
  logic [2:0]      count;

  axo_fetch_queue #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .RESET_VEC (64'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_re    (prog_re),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .redir      (redir),
    .redir_pc   (redir_pc),
    .deq_valid  (deq_valid),
    .deq_ready  (deq_ready),
    .deq_inst   (deq_inst),
    .deq_pc     (deq_pc),
    .deq_fault  (deq_fault),
    .count      (count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of entries, the fetch PC and a halted flag.
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc;
  bit          m_halt;

  typedef struct {
    logic        r;
    logic [63:0] rpc;
    logic        rdy;
    logic        dq;
    logic        e_re;
    logic [63:0] e_addr;
    int          e_cnt;
    logic        e_valid;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[8];

  task automatic step(input logic r, input logic [63:0] rpc, input logic rdy,
                      input logic dq, input int ti);
    logic [31:0] d;
    bit          exp_re;
    bit          take;
    bit          enq;
    int          n;
    ent_t        e;
    d = $urandom;
    redir = r; redir_pc = rpc; prog_ready = rdy; deq_ready = dq; prog_data = d;
    #2;
    n = mq.size();
    exp_re = !m_halt && (m_pc[1:0] == 2'b00) && (n < DEPTH) && !r;
    chk("prog_re", prog_re, exp_re);
    chk("prog_addr", prog_addr, m_pc);
    chk("count", count, n);
    chk("deq_valid", deq_valid, n > 0);
    if (n > 0) begin
      chk("deq_pc", deq_pc, mq[0].pc);
      chk("deq_inst", deq_inst, mq[0].inst);
      chk("deq_fault", deq_fault, mq[0].fault);
    end
    if (ti >= 0) begin
      chk("tbl_re", prog_re, tbl[ti].e_re);
      chk("tbl_addr", prog_addr, tbl[ti].e_addr);
      chk("tbl_count", count, tbl[ti].e_cnt);
      chk("tbl_valid", deq_valid, tbl[ti].e_valid);
      chk("tbl_pc", deq_pc, tbl[ti].e_pc);
    end
    @(posedge clk);
    take = (n > 0) && dq;
    if (take)
      $display("deq pc=0x%0h inst=0x%08h fault=%0d", mq[0].pc, mq[0].inst, mq[0].fault);
    if (r) begin
      mq.delete();
      m_pc = rpc;
      m_halt = 0;
    end else begin
      enq = 0;
      if (!m_halt) begin
        if (m_pc[1:0] == 2'b00) begin
          if (exp_re && rdy) begin
            e = '{d, m_pc, 1'b0};
            enq = 1;
            m_pc = m_pc + 64'd4;
          end
        end else if (n < DEPTH) begin
          e = '{32'h0, m_pc, 1'b1};
          enq = 1;
          m_halt = 1;
        end
      end
      if (take) void'(mq.pop_front());
      if (enq) mq.push_back(e);
    end
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h00, 0, 1'b0, 64'h0};
    tbl[1] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h04, 1, 1'b1, 64'h0};
    tbl[2] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h08, 2, 1'b1, 64'h0};
    tbl[3] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0C, 3, 1'b1, 64'h0};
    tbl[4] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h10, 4, 1'b1, 64'h0};
    tbl[5] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h10, 4, 1'b1, 64'h0};
    tbl[6] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h10, 3, 1'b1, 64'h4};
    tbl[7] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h14, 4, 1'b1, 64'h4};

    // Reset state, with prog_ready high to show prog_re is held low in reset.
    rst = 1'b0; redir = 1'b0; redir_pc = '0; prog_ready = 1'b1;
    deq_ready = 1'b0; prog_data = '0;
    #12;
    chk("rst_prog_re", prog_re, 0);
    chk("rst_count", count, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_deq_inst", deq_inst, 0);
    chk("rst_deq_pc", deq_pc, 0);
    chk("rst_deq_fault", deq_fault, 0);
    chk("rst_prog_addr", prog_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete(); m_pc = 64'h0; m_halt = 0;

    // Fill to full, then one dequeue frees a slot that is refilled next cycle.
    for (int i = 0; i < 8; i++) step(tbl[i].r, tbl[i].rpc, tbl[i].rdy, tbl[i].dq, i);

    // Drop to count=3 with a fetch stalled on the bus, then redirect.
    step(1'b0, 64'h0, 1'b0, 1'b1, -1);
    step(1'b0, 64'h0, 1'b0, 1'b0, -1);
    step(1'b1, 64'h200, 1'b1, 1'b0, -1);
    chk("redir_count", count, 0);
    chk("redir_valid", deq_valid, 0);
    chk("redir_addr", prog_addr, 64'h200);

    // Steady state: one instruction per cycle, occupancy stays at one.
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 64'h0, 1'b1, 1'b1, -1);
      chk("steady_count", count, 1);
      chk("steady_pc", deq_pc, 64'h200 + 64'(4 * (k - 1)));
    end

    // Misaligned redirect: single fault entry, then halted until redirected.
    step(1'b1, 64'h102, 1'b1, 1'b1, -1);
    step(1'b0, 64'h0, 1'b1, 1'b0, -1);
    chk("mis_count", count, 1);
    chk("mis_fault", deq_fault, 1);
    chk("mis_pc", deq_pc, 64'h102);
    chk("mis_inst", deq_inst, 0);
    chk("mis_re", prog_re, 0);
    for (int k = 0; k < 3; k++) step(1'b0, 64'h0, 1'b1, 1'b0, -1);
    chk("halt_count", count, 1);
    step(1'b1, 64'h104, 1'b1, 1'b1, -1);
    step(1'b0, 64'h0, 1'b1, 1'b0, -1);
    chk("resume_pc", deq_pc, 64'h104);
    chk("resume_fault", deq_fault, 0);

    // Top-of-address-space wrap.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, -1);
    step(1'b0, 64'h0, 1'b1, 1'b0, -1);
    chk("wrap_addr", prog_addr, 64'h0);
    chk("wrap_pc", deq_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 64'h0, 1'b1, 1'b0, -1);

    // Asynchronous reset mid-stream takes effect without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", deq_valid, 0);
    chk("arst_re", prog_re, 0);
    chk("arst_addr", prog_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mq.delete(); m_pc = 64'h0; m_halt = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [63:0] rpc;
      r = ($urandom_range(0, 15) == 0);
      rpc = {32'h0, 16'h0, 16'($urandom)} & ~64'h3;
      if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rpc = rpc | 64'hFFFF_FFFF_FFFF_FF00;
      step(r, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
